ps2_key_ctrl: RTL and testbench
===============================

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter: DEPTH, 8, event FIFO depth (power of two, >=2).
REQ-002 Parameter: TIMEOUT, 65535, idle cycles after which a pending prefix is abandoned.
REQ-003 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: rx_valid  input  1  one-cycle strobe, received scan byte present.
REQ-006 Port: rx_byte  input  8  received scan byte, valid with rx_valid.
REQ-007 Port: rx_err  input  1  frame error qualifier, sampled with rx_valid.
REQ-008 Port: ev_valid  output  1  FIFO head holds an event.
REQ-009 Port: ev_ready  input  1  consumer accepts head event.
REQ-010 Port: ev_code  output  8  head event scan code.
REQ-011 Port: ev_brk  output  1  head event is a key release.
REQ-012 Port: ev_ext  output  1  head event carried E0 prefix.
REQ-013 Port: fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 Port: key_cnt  output  8  count of accepted make (press) events, wraps.
REQ-015 Port: ovf  output  1  sticky overflow flag.
REQ-016 Port: ovf_clr  input  1  clears ovf.

Function
REQ-017 Decoder FSM states SHALL be IDLE, EXT, BRK, EXT_BRK; only rx_valid=1 cycles advance it.
REQ-018 rx_valid with rx_err=1 SHALL discard the byte and force IDLE, no push.
REQ-019 Byte 0x00 or 0xFF SHALL be discarded and force IDLE, no push.
REQ-020 Byte 0xE0: IDLE->EXT, EXT->EXT, BRK->IDLE, EXT_BRK->IDLE (latter two: sequence dropped).
REQ-021 Byte 0xF0: IDLE->BRK, EXT->EXT_BRK, BRK->BRK, EXT_BRK->EXT_BRK.
REQ-022 Any other byte SHALL push {code=byte, brk=(state in BRK,EXT_BRK), ext=(state in EXT,EXT_BRK)} and return to IDLE.
REQ-023 FIFO SHALL be first-word-fall-through; pushed event visible on ev_valid/ev_* the cycle after the rx_valid cycle when FIFO was empty.
REQ-024 Pop occurs when ev_valid & ev_ready; ev_ready while empty SHALL have no effect.
REQ-025 ev_code/ev_brk/ev_ext SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-026 Push when full and no pop SHALL drop the event, leave FIFO unchanged, set ovf.
REQ-027 Simultaneous push and pop when full SHALL accept the push; fifo_level stays DEPTH, ovf unchanged.
REQ-028 Simultaneous push and pop when non-full, non-empty SHALL leave fifo_level unchanged.
REQ-029 ovf_clr clears ovf next cycle; new overflow in same cycle as ovf_clr SHALL leave ovf=1.
REQ-030 key_cnt SHALL increment by 1 (mod 256) only for accepted pushes with brk=0; dropped events do not count.
REQ-031 Timeout counter SHALL reset on every rx_valid and in IDLE; in non-IDLE, after TIMEOUT consecutive cycles without rx_valid FSM returns to IDLE, no push.
REQ-032 FIFO read/write pointers SHALL wrap modulo DEPTH with fifo_level tracking full vs empty unambiguously.

Reset
REQ-033 reset=1 SHALL force IDLE, empty FIFO, ev_valid=0, ev_code=0, ev_brk=0, ev_ext=0, fifo_level=0, key_cnt=0, ovf=0, timeout counter 0.
REQ-034 reset mid-sequence (e.g. after E0) SHALL discard the pending prefix and all queued events.
REQ-035 rx_valid during reset SHALL be ignored.

Verification
REQ-036 Bytes 1C, F0, 1C, ev_ready=1 -> events {1C,brk0,ext0},{1C,brk1,ext0}; key_cnt=1.
REQ-037 Bytes E0,75,E0,F0,75 -> {75,0,1},{75,1,1}; key_cnt=1.
REQ-038 ev_ready=0, DEPTH+1 make bytes 16 -> fifo_level=DEPTH, ovf=1, key_cnt=DEPTH; ovf_clr -> ovf=0.
REQ-039 Full FIFO, push and pop same cycle -> fifo_level=DEPTH, ovf=0, popped head is oldest, new event at tail.
REQ-040 E0 then TIMEOUT idle cycles then 1C -> {1C,0,0}; F0 then rx_err byte then 1C -> {1C,0,0}; byte FF -> no event.
REQ-041 Reset asserted with 3 queued events and pending F0 -> all outputs zero next cycle; subsequent 1C -> {1C,0,0}.

Source files
------------

// File: rtl/ps2_key_ctrl.sv
// sync_fifo: generic first-word-fall-through FIFO with power-of-two depth and occupancy count.
// Latency: a write shows at head_dat the cycle after it is written when the FIFO was empty.
// Backpressure: none internally; the caller qualifies wr/rd against full/empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic [W-1:0]               wr_dat,
    input  logic                       rd,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at DEPTH; cnt disambiguates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr, rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign level    = cnt;
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
endmodule

// ps2_key_ctrl: decodes PS/2 set-2 scan bytes (E0/F0 prefixes) into key events queued in a FIFO.
// Latency: an event is visible on ev_* the cycle after its final byte when the FIFO was empty.
// Backpressure: ev_valid/ev_ready; pushes into a full FIFO without a pop are dropped and set ovf.
module ps2_key_ctrl #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_byte,
    input  logic                       rx_err,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [7:0]                 ev_code,
    output logic                       ev_brk,
    output logic                       ev_ext,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [7:0]                 key_cnt,
    output logic                       ovf,
    input  logic                       ovf_clr
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0] B_EXT = 8'hE0;
    localparam logic [7:0] B_BRK = 8'hF0;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_nxt;
    logic          push;
    ev_t           push_ev;
    ev_t           head_ev;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        push         = 1'b0;
        push_ev      = '0;
        push_ev.code = rx_byte;
        push_ev.brk  = (state == BRK) || (state == EXT_BRK);
        push_ev.ext  = (state == EXT) || (state == EXT_BRK);
        if (rx_valid) begin
            if (rx_err || rx_byte == 8'h00 || rx_byte == 8'hFF) begin
                state_nxt = IDLE;
            end else if (rx_byte == B_EXT) begin
                // E0 after a break prefix is not a legal sequence; drop it.
                unique case (state)
                    IDLE, EXT: state_nxt = EXT;
                    default:   state_nxt = IDLE;
                endcase
            end else if (rx_byte == B_BRK) begin
                unique case (state)
                    IDLE, BRK: state_nxt = BRK;
                    default:   state_nxt = EXT_BRK;
                endcase
            end else begin
                push      = 1'b1;
                state_nxt = IDLE;
            end
        end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        tmo_nxt = tmo_cnt + TW'(1);
        if (rx_valid || state == IDLE || tmo_cnt == TMO_LAST) begin
            tmo_nxt = '0;
        end
    end

    assign pop = ev_valid && ev_ready;
    assign wr  = push && (!fifo_full || pop);

    sync_fifo #(
        .W     ($bits(ev_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .wr_dat   (push_ev),
        .rd       (pop),
        .head_dat (head_ev),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Head fields are forced to zero when empty so stale memory never leaks out.
    assign ev_valid = !fifo_empty;
    assign ev_code  = ev_valid ? head_ev.code : 8'h00;
    assign ev_brk   = ev_valid & head_ev.brk;
    assign ev_ext   = ev_valid & head_ev.ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            if (wr && !push_ev.brk) begin
                key_cnt <= key_cnt + 8'd1;
            end
            if (push && fifo_full && !pop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: directed scenarios plus random byte streams against a prefix-flag/queue model.
module tb_ps2_key_ctrl;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          rx_err;
    logic          ev_valid;
    logic          ev_ready;
    logic [7:0]    ev_code;
    logic          ev_brk;
    logic          ev_ext;
    logic [LW-1:0] fifo_level;
    logic [7:0]    key_cnt;
    logic          ovf;
    logic          ovf_clr;

    always #5 clk = ~clk;

    ps2_key_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_err     (rx_err),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_brk     (ev_brk),
        .ev_ext     (ev_ext),
        .fifo_level (fifo_level),
        .key_cnt    (key_cnt),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    typedef struct {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } mev_t;

    // Model: pending prefixes are two flags, the queue holds accepted events in order.
    mev_t       mq[$];
    bit         m_ext;
    bit         m_brk;
    int         m_idle;
    logic [7:0] m_kc;
    bit         m_ovf;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ext  = 0;
        m_brk  = 0;
        m_idle = 0;
        m_kc   = 8'h00;
        m_ovf  = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit e, input bit rdy, input bit clr);
        bit   pop;
        bit   have;
        bit   acc;
        mev_t ev;
        pop  = (mq.size() > 0) && rdy;
        have = 0;
        ev   = '{code: b, brk: m_brk, ext: m_ext};
        if (v) begin
            m_idle = 0;
            if (e || b == 8'h00 || b == 8'hFF) begin
                m_ext = 0; m_brk = 0;
            end else if (b == 8'hE0) begin
                if (m_brk) begin m_ext = 0; m_brk = 0; end
                else m_ext = 1;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else begin
                have  = 1;
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle >= TIMEOUT) begin
                m_ext = 0; m_brk = 0; m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end
        acc = have && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(ev);
            if (!ev.brk) m_kc = m_kc + 8'd1;
        end
        if (have && !acc) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic check_all(input string tag);
        bit exv;
        exv = mq.size() > 0;
        chk({tag, ".vld"},   ev_valid, exv);
        chk({tag, ".code"},  ev_code,  exv ? mq[0].code : 8'h00);
        chk({tag, ".brk"},   ev_brk,   exv ? mq[0].brk : 1'b0);
        chk({tag, ".ext"},   ev_ext,   exv ? mq[0].ext : 1'b0);
        chk({tag, ".level"}, fifo_level, mq.size());
        chk({tag, ".kcnt"},  key_cnt,  m_kc);
        chk({tag, ".ovf"},   ovf,      m_ovf);
    endtask

    task automatic step(input string tag, input bit v, input logic [7:0] b, input bit e,
                        input bit rdy, input bit clr);
        rx_valid = v;
        rx_byte  = b;
        rx_err   = e;
        ev_ready = rdy;
        ovf_clr  = clr;
        model_step(v, b, e, rdy, clr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic send(input string tag, input logic [7:0] b, input bit rdy);
        step(tag, 1'b1, b, 1'b0, rdy, 1'b0);
    endtask

    task automatic idle(input string tag, input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(tag, 1'b0, 8'h00, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h1C;
        rx_err   = 1'b0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; rx_err = 1'b0;
        ev_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();

        do_reset("rst0");
        chk("rst0_vld", ev_valid, 1'b0);
        chk("rst0_lvl", fifo_level, 0);

        // make, break with ready held high
        send("r36a", 8'h1C, 1'b1);
        chk("r36_make_code", ev_code, 8'h1C);
        chk("r36_make_brk", ev_brk, 1'b0);
        send("r36b", 8'hF0, 1'b1);
        send("r36c", 8'h1C, 1'b1);
        chk("r36_brk_code", ev_code, 8'h1C);
        chk("r36_brk_flag", ev_brk, 1'b1);
        chk("r36_kcnt", key_cnt, 8'd1);
        idle("r36d", 2, 1'b1);

        // extended make and break
        do_reset("rst1");
        send("r37a", 8'hE0, 1'b0);
        send("r37b", 8'h75, 1'b0);
        send("r37c", 8'hE0, 1'b0);
        send("r37d", 8'hF0, 1'b0);
        send("r37e", 8'h75, 1'b0);
        chk("r37_head_ext", ev_ext, 1'b1);
        chk("r37_head_brk", ev_brk, 1'b0);
        step("r37f", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("r37_tail_brk", ev_brk, 1'b1);
        chk("r37_tail_ext", ev_ext, 1'b1);
        chk("r37_kcnt", key_cnt, 8'd1);

        // overflow, then clear, then clear coinciding with new overflow
        do_reset("rst2");
        for (int i = 0; i <= DEPTH; i++) send("r38", 8'h16, 1'b0);
        chk("r38_lvl", fifo_level, DEPTH);
        chk("r38_ovf", ovf, 1'b1);
        chk("r38_kcnt", key_cnt, DEPTH);
        step("r38clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("r38_ovf_clr", ovf, 1'b0);
        step("r29", 1'b1, 8'h16, 1'b0, 1'b0, 1'b1);
        chk("r29_ovf_set_wins", ovf, 1'b1);

        // full FIFO, push and pop in the same cycle
        do_reset("rst3");
        for (int i = 0; i < DEPTH; i++) send("r39fill", 8'h10 + 8'(i), 1'b0);
        send("r39pp", 8'h20, 1'b1);
        chk("r39_lvl", fifo_level, DEPTH);
        chk("r39_ovf", ovf, 1'b0);
        chk("r39_head", ev_code, 8'h11);
        idle("r39drain", DEPTH + 1, 1'b1);
        chk("r39_empty", ev_valid, 1'b0);

        // timeout boundary, frame error, discarded bytes
        do_reset("rst4");
        send("r40a", 8'hE0, 1'b0);
        idle("r40a_idle", TIMEOUT, 1'b0);
        send("r40a_1c", 8'h1C, 1'b0);
        chk("r40_tmo_ext", ev_ext, 1'b0);
        step("r40a_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        send("r40b", 8'hE0, 1'b0);
        idle("r40b_idle", TIMEOUT - 1, 1'b0);
        send("r40b_1c", 8'h1C, 1'b0);
        chk("r40_notmo_ext", ev_ext, 1'b1);
        step("r40b_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        send("r40c", 8'hF0, 1'b0);
        step("r40c_err", 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
        send("r40c_1c", 8'h1C, 1'b0);
        chk("r40_err_brk", ev_brk, 1'b0);
        step("r40c_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        send("r40d", 8'hFF, 1'b0);
        chk("r40_ff_none", ev_valid, 1'b0);
        send("r40e", 8'hF0, 1'b0);
        send("r40e_e0", 8'hE0, 1'b0);
        send("r40e_1c", 8'h1C, 1'b0);
        chk("r40_f0e0_drop", ev_brk, 1'b0);

        // reset with queued events and pending break prefix
        do_reset("rst5");
        send("r41a", 8'h1C, 1'b0);
        send("r41b", 8'h32, 1'b0);
        send("r41c", 8'h21, 1'b0);
        send("r41d", 8'hF0, 1'b0);
        do_reset("r41rst");
        chk("r41_code0", ev_code, 8'h00);
        chk("r41_kcnt0", key_cnt, 8'h00);
        send("r41e", 8'h1C, 1'b0);
        chk("r41_code", ev_code, 8'h1C);
        chk("r41_brk", ev_brk, 1'b0);

        // random byte streams with varying consumer readiness
        do_reset("rst6");
        for (int i = 0; i < 3000; i++) begin
            int         r;
            bit         v;
            bit         e;
            bit         rdy;
            bit         clr;
            logic [7:0] b;
            r = int'($urandom_range(0, 99));
            if (r < 15)      b = 8'hE0;
            else if (r < 32) b = 8'hF0;
            else if (r < 35) b = 8'h00;
            else if (r < 38) b = 8'hFF;
            else             b = 8'($urandom_range(0, 255));
            v   = ($urandom_range(0, 2) != 0);
            e   = ($urandom_range(0, 15) == 0);
            rdy = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 31) == 0);
            step("rnd", v, b, e, rdy, clr);
            if ($urandom_range(0, 149) == 0) idle("rnd_idle", TIMEOUT - 2 + int'($urandom_range(0, 3)), rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
